// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the multi-step LFSR family.
package lfsr_pkg;

    localparam logic [3:0]  TAPS_W4  = 4'h3;
    localparam logic [15:0] TAPS_W16 = 16'h100B;

    // Default feedback tap mask for a given width, zero-extended to 32 bits.
    function automatic logic [31:0] default_taps(input int width);
        logic [31:0] taps_v;
        case (width)
            4:       taps_v = {28'h0000000, TAPS_W4};
            16:      taps_v = {16'h0000, TAPS_W16};
            default: taps_v = 32'h0000_0003;
        endcase
        return taps_v;
    endfunction

    // State that an XNOR (all-ones) or XOR (all-zeros) LFSR can never leave.
    function automatic logic [31:0] lockup_val(input logic xnor_mode, input int width);
        logic [31:0] val_v;
        if (xnor_mode) begin
            val_v = 32'hFFFF_FFFF >> (32 - width);
        end else begin
            val_v = 32'h0000_0000;
        end
        return val_v;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Fibonacci shift: feedback enters at the MSB, state shifts right.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
    parameter bit              XNOR_MODE = 1'b1
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    logic parity_s;
    logic fb_s;

    // Parity of the tapped bits, optionally inverted, shifted in at the top.
    always_comb begin
        parity_s = ^(state_i & TAPS);
        if (XNOR_MODE) begin
            fb_s = ~parity_s;
        end else begin
            fb_s = parity_s;
        end
        state_o = {fb_s, state_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/lfsr_multi.sv
// LFSR advancing STEPS shifts per enabled cycle, with seed load, lockup
// substitution, wrap detection against the start value and an advance counter.
module lfsr_multi
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
    parameter int               STEPS     = 1,
    parameter bit               XNOR_MODE = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             wrap,
    output logic             lockup_err,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] LOCKUP = WIDTH'(lockup_val(XNOR_MODE, WIDTH));

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_multi: WIDTH must be 3..32");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_multi: STEPS must be 1..WIDTH");
    end
    if (TAPS == '0) begin : g_bad_taps
        $error("lfsr_multi: TAPS must be non-zero");
    end
    if (RESET_VAL == LOCKUP) begin : g_bad_reset
        $error("lfsr_multi: RESET_VAL must not be the lockup value");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_err_q, lockup_err_d;
    logic [WIDTH-1:0] adv_s;

    // Chain of single-shift stages; each stage reads the previous stage's output.
    for (genvar i = 0; i < STEPS; i++) begin : g_step
        logic [WIDTH-1:0] in_s;
        logic [WIDTH-1:0] out_s;
        if (i == 0) begin : g_first
            assign in_s = state_q;
        end else begin : g_next
            assign in_s = g_step[i-1].out_s;
        end
        lfsr_step #(
            .WIDTH     (WIDTH),
            .TAPS      (TAPS),
            .XNOR_MODE (XNOR_MODE)
        ) u_step (
            .state_i (in_s),
            .state_o (out_s)
        );
    end

    assign adv_s = g_step[STEPS-1].out_s;

    // Next-state selection: load beats en; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        cnt_d        = cnt_q;
        valid_d      = 1'b0;
        wrap_d       = 1'b0;
        lockup_err_d = 1'b0;
        if (load) begin
            cnt_d = '0;
            if (seed == LOCKUP) begin
                state_d      = RESET_VAL;
                start_d      = RESET_VAL;
                lockup_err_d = 1'b1;
            end else begin
                state_d = seed;
                start_d = seed;
            end
        end else if (en) begin
            state_d = adv_s;
            valid_d = 1'b1;
            if (adv_s == start_q) begin
                wrap_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset overriding load and en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_VAL;
            start_q      <= RESET_VAL;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            wrap_q       <= 1'b0;
            lockup_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            wrap_q       <= wrap_d;
            lockup_err_q <= lockup_err_d;
        end
    end

    assign out        = state_q;
    assign valid      = valid_q;
    assign wrap       = wrap_q;
    assign lockup_err = lockup_err_q;
    assign cnt        = cnt_q;

endmodule

// File: tb/tb_lfsr_multi.sv
// Self-checking bench for lfsr_multi: default, two-step and 4-bit XOR instances.
module tb_lfsr_multi;

    typedef struct packed {
        logic [15:0] out;
        logic        valid;
        logic        wrap;
        logic        lock;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic [3:0] out;
        logic       valid;
        logic       wrap;
        logic [3:0] cnt;
    } exp4_t;

    localparam logic [15:0] TAPS_REF = 16'h100B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en_a, load_a, en_b, load_b, en_c, load_c;
    logic [15:0] seed_a, seed_b;
    logic [3:0]  seed_c;
    logic [15:0] out_a, cnt_a, out_b, cnt_b;
    logic [3:0]  out_c, cnt_c;
    logic        valid_a, wrap_a, lock_a, valid_b, wrap_b, lock_b, valid_c, wrap_c, lock_c;

    exp_t  obs_a, obs_b;
    exp4_t obs_c;
    assign obs_a = {out_a, valid_a, wrap_a, lock_a, cnt_a};
    assign obs_b = {out_b, valid_b, wrap_b, lock_b, cnt_b};
    assign obs_c = {out_c, valid_c, wrap_c, cnt_c};

    exp_t  sb_a[$];
    exp_t  sb_b[$];
    exp4_t sb_c[$];

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_state, m_start, m_cnt;

    lfsr_multi u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .load(load_a), .seed(seed_a),
        .out(out_a), .valid(valid_a), .wrap(wrap_a), .lockup_err(lock_a), .cnt(cnt_a)
    );

    lfsr_multi #(.STEPS(2)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .load(load_b), .seed(seed_b),
        .out(out_b), .valid(valid_b), .wrap(wrap_b), .lockup_err(lock_b), .cnt(cnt_b)
    );

    lfsr_multi #(.WIDTH(4), .TAPS(4'h3), .XNOR_MODE(1'b0), .RESET_VAL(4'h1)) u_dut_c (
        .clk(clk), .rst(rst), .en(en_c), .load(load_c), .seed(seed_c),
        .out(out_c), .valid(valid_c), .wrap(wrap_c), .lockup_err(lock_c), .cnt(cnt_c)
    );

    // Bit-by-bit reference shift for the default XNOR configuration.
    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (TAPS_REF[i]) p = p ^ s[i];
        end
        return {~p, s[15:1]};
    endfunction

    // Drive one cycle on instance A, push the model's expectation, sample after the edge.
    task automatic apply(input logic r, input logic l, input logic e, input logic [15:0] sd);
        exp_t x;
        rst = r; load_a = l; en_a = e; seed_a = sd;
        x = '0;
        if (r) begin
            m_state = 16'h0000; m_start = 16'h0000; m_cnt = 16'h0000;
        end else if (l) begin
            if (sd == 16'hFFFF) begin
                m_state = 16'h0000; x.lock = 1'b1;
            end else begin
                m_state = sd;
            end
            m_start = m_state; m_cnt = 16'h0000;
        end else if (e) begin
            m_state = ref_step(m_state);
            x.valid = 1'b1;
            if (m_state == m_start) begin
                x.wrap = 1'b1; m_cnt = 16'h0000;
            end else begin
                m_cnt = m_cnt + 16'h0001;
            end
        end
        x.out = m_state; x.cnt = m_cnt;
        sb_a.push_back(x);
        @(posedge clk); #1;
        rst = 1'b0; load_a = 1'b0; en_a = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        apply(1'b1, 1'b0, 1'b0, 16'h0000);
        e = sb_a.pop_front(); vectors++;
        if (obs_a !== e) begin
            $display("FAIL reset: got %h want %h", obs_a, e); miscompares++;
        end
        apply(1'b1, 1'b1, 1'b1, 16'hABCD);
        e = sb_a.pop_front(); vectors++;
        if (obs_a !== e || out_a !== 16'h0000) begin
            $display("FAIL reset_load_en: got %h want %h", obs_a, e); miscompares++;
        end
    endtask

    task automatic test_advance();
        exp_t e;
        logic [15:0] want [2];
        want[0] = 16'h8000; want[1] = 16'hC000;
        apply(1'b1, 1'b0, 1'b0, 16'h0000);
        void'(sb_a.pop_front());
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b1, 16'h0000);
            e = sb_a.pop_front(); vectors++;
            if (obs_a !== e || out_a !== want[i] || cnt_a !== 16'(i + 1) || valid_a !== 1'b1) begin
                $display("FAIL advance%0d: got %h want %h", i, obs_a, e); miscompares++;
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        logic [15:0] seeds [3];
        seeds[0] = 16'hFFFF; seeds[1] = 16'h1234; seeds[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b0, seeds[i]);
            e = sb_a.pop_front(); vectors++;
            if (obs_a !== e) begin
                $display("FAIL load%0d seed %h: got %h want %h", i, seeds[i], obs_a, e); miscompares++;
            end
            apply(1'b0, 1'b0, 1'b0, 16'h0000);
            e = sb_a.pop_front(); vectors++;
            if (obs_a !== e || lock_a !== 1'b0) begin
                $display("FAIL load%0d_idle: got %h want %h", i, obs_a, e); miscompares++;
            end
        end
    endtask

    task automatic test_load_en();
        exp_t e;
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        void'(sb_a.pop_front());
        apply(1'b0, 1'b1, 1'b1, 16'hABCD);
        e = sb_a.pop_front(); vectors++;
        if (obs_a !== e || out_a !== 16'hABCD || valid_a !== 1'b0) begin
            $display("FAIL load_en: got %h want %h", obs_a, e); miscompares++;
        end
    endtask

    task automatic test_hold();
        exp_t e;
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        void'(sb_a.pop_front());
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 16'h5555);
            e = sb_a.pop_front(); vectors++;
            if (obs_a !== e) begin
                $display("FAIL hold%0d: got %h want %h", i, obs_a, e); miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b1, 16'h0000);
            void'(sb_a.pop_front());
        end
        apply(1'b1, 1'b0, 1'b1, 16'h0000);
        e = sb_a.pop_front(); vectors++;
        if (obs_a !== e || out_a !== 16'h0000 || cnt_a !== 16'h0000) begin
            $display("FAIL reset_mid: got %h want %h", obs_a, e); miscompares++;
        end
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        e = sb_a.pop_front(); vectors++;
        if (obs_a !== e || out_a !== 16'h8000) begin
            $display("FAIL reset_mid_first: got %h want %h", obs_a, e); miscompares++;
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic r, l, en;
        logic [15:0] sd;
        for (int i = 0; i < 80; i++) begin
            r  = ($urandom_range(0, 15) == 0);
            l  = ($urandom_range(0, 7) == 0);
            en = $urandom_range(0, 1) == 1;
            sd = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            apply(r, l, en, sd);
            e = sb_a.pop_front(); vectors++;
            if (obs_a !== e) begin
                $display("FAIL random%0d r%b l%b e%b: got %h want %h", i, r, l, en, obs_a, e); miscompares++;
            end
        end
    endtask

    task automatic test_steps2();
        exp_t e;
        rst = 1'b1; en_b = 1'b0; load_b = 1'b0; seed_b = 16'h0000;
        sb_b.push_back({16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(posedge clk); #1; rst = 1'b0;
        e = sb_b.pop_front(); vectors++;
        if (obs_b !== e) begin
            $display("FAIL steps2_reset: got %h want %h", obs_b, e); miscompares++;
        end
        sb_b.push_back({16'hC000, 1'b1, 1'b0, 1'b0, 16'h0001});
        sb_b.push_back({16'hF000, 1'b1, 1'b0, 1'b0, 16'h0002});
        for (int i = 0; i < 2; i++) begin
            en_b = 1'b1;
            @(posedge clk); #1; en_b = 1'b0;
            e = sb_b.pop_front(); vectors++;
            if (obs_b !== e) begin
                $display("FAIL steps2_adv%0d: got %h want %h", i, obs_b, e); miscompares++;
            end
        end
    endtask

    task automatic test_wrap4();
        exp4_t e;
        logic [3:0] seq [15];
        seq = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
        rst = 1'b1; en_c = 1'b0; load_c = 1'b0; seed_c = 4'h0;
        sb_c.push_back({4'h1, 1'b0, 1'b0, 4'h0});
        @(posedge clk); #1; rst = 1'b0;
        e = sb_c.pop_front(); vectors++;
        if (obs_c !== e) begin
            $display("FAIL wrap4_reset: got %h want %h", obs_c, e); miscompares++;
        end
        for (int i = 0; i < 15; i++) begin
            sb_c.push_back({seq[i], 1'b1, (i == 14), (i == 14) ? 4'h0 : 4'(i + 1)});
            en_c = 1'b1;
            @(posedge clk); #1; en_c = 1'b0;
            e = sb_c.pop_front(); vectors++;
            if (obs_c !== e) begin
                $display("FAIL wrap4_adv%0d: got %h want %h", i + 1, obs_c, e); miscompares++;
            end
        end
        sb_c.push_back({4'h1, 1'b0, 1'b0, 4'h0});
        @(posedge clk); #1;
        e = sb_c.pop_front(); vectors++;
        if (obs_c !== e) begin
            $display("FAIL wrap4_idle: got %h want %h", obs_c, e); miscompares++;
        end
    endtask

    initial begin
        rst = 1'b0;
        en_a = 1'b0; load_a = 1'b0; seed_a = 16'h0000;
        en_b = 1'b0; load_b = 1'b0; seed_b = 16'h0000;
        en_c = 1'b0; load_c = 1'b0; seed_c = 4'h0;
        m_state = 16'h0000; m_start = 16'h0000; m_cnt = 16'h0000;
        @(posedge clk); #1;
        test_reset();
        test_advance();
        test_load();
        test_load_en();
        test_hold();
        test_reset_mid();
        test_random();
        test_steps2();
        test_wrap4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
